// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX->MEM pipeline boundary with a two-entry skid buffer.
//   Captures the ALU result, store data, rd and the control bundle. The branch
//   condition is resolved from the ALU flags at capture time.
//   The main entry drives every out_* port. The skid entry absorbs one beat
//   when MEM stalls, so in_ready comes straight from a flop.
// Ports:
//   clk, reset (sync, active-low)
//   in_valid/in_ready           : upstream handshake
//   alu_s, alu_c/v/z/n          : ALU result and flags
//   is_branch, br_funct3        : branch qualifier and RISC-V funct3
//   rd_addr, store_data, ctrl_in: side-band fields
//   flush                       : drop every held and incoming beat
//   out_valid/out_ready         : downstream handshake
//   out_result, out_store_data, out_rd_addr, out_ctrl, out_branch_taken
// Optional: `define EX_MEM_STALL_CNT_EN adds stall_cycles[31:0], a saturating
//   count of edges with out_valid=1 and out_ready=0 (cleared by reset only).
module ex_mem_stage_reg #(
  parameter int size   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [size-1:0]   alu_s,
  input  logic              alu_c,
  input  logic              alu_v,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              is_branch,
  input  logic [2:0]        br_funct3,
  input  logic [4:0]        rd_addr,
  input  logic [size-1:0]   store_data,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [size-1:0]   out_result,
  output logic [size-1:0]   out_store_data,
  output logic [4:0]        out_rd_addr,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_branch_taken
`ifdef EX_MEM_STALL_CNT_EN
  ,output logic [31:0]      stall_cycles
`endif
);

  typedef struct packed {
    logic [size-1:0]   result;
    logic [size-1:0]   store_data;
    logic [4:0]        rd_addr;
    logic [CTRL_W-1:0] ctrl;
    logic              br_taken;
  } beat_t;

  beat_t main_q, skid_q, in_beat;
  logic  main_valid, skid_valid;
  logic  br_taken, pop, acc;

  // Branch resolution; C=1 means no borrow, so unsigned less-than is ~C.
  always_comb begin
    br_taken = 1'b0;
    if (is_branch) begin
      case (br_funct3)
        3'b000:  br_taken = alu_z;
        3'b001:  br_taken = ~alu_z;
        3'b100:  br_taken = alu_n ^ alu_v;
        3'b101:  br_taken = ~(alu_n ^ alu_v);
        3'b110:  br_taken = ~alu_c;
        3'b111:  br_taken = alu_c;
        default: br_taken = 1'b0;
      endcase
    end
  end

  assign in_beat  = {alu_s, store_data, rd_addr, ctrl_in, br_taken};

  // in_ready depends only on the skid flop and reset, never on out_ready.
  assign in_ready = reset & ~skid_valid;
  assign pop      = main_valid & out_ready;
  assign acc      = in_valid & in_ready & ~flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || (pop && !skid_valid)) begin
      // Main is free (or drains this edge with nothing behind it).
      main_valid <= acc;
      if (acc) main_q <= in_beat;
    end else if (pop) begin
      // Skid advances to main; main_valid stays set.
      main_q     <= skid_q;
      skid_valid <= acc;
      if (acc) skid_q <= in_beat;
    end else if (acc) begin
      // MEM stalled with main occupied: overflow goes to skid.
      skid_q     <= in_beat;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid        = main_valid;
  assign out_result       = main_q.result;
  assign out_store_data   = main_q.store_data;
  assign out_rd_addr      = main_q.rd_addr;
  assign out_ctrl         = main_q.ctrl;
  assign out_branch_taken = main_q.br_taken;

`ifdef EX_MEM_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      stall_cycles <= '0;
    else if (main_valid && !out_ready && (stall_cycles != 32'hFFFF_FFFF))
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Bench for ex_mem_stage_reg: directed scenarios plus random traffic, checked
// against a queue of expected beats pushed on accept and popped on delivery.
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready;
  logic [31:0] alu_s, store_data;
  logic        alu_c, alu_v, alu_z, alu_n, is_branch, flush;
  logic [2:0]  br_funct3;
  logic [4:0]  rd_addr;
  logic [3:0]  ctrl_in;
  logic        out_valid, out_ready, out_branch_taken;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd_addr;
  logic [3:0]  out_ctrl;
`ifdef EX_MEM_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  always #5 clk = ~clk;

  ex_mem_stage_reg #(.size(32), .CTRL_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_s(alu_s), .alu_c(alu_c), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
    .is_branch(is_branch), .br_funct3(br_funct3), .rd_addr(rd_addr),
    .store_data(store_data), .ctrl_in(ctrl_in), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd_addr(out_rd_addr),
    .out_ctrl(out_ctrl), .out_branch_taken(out_branch_taken)
`ifdef EX_MEM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic br_ref(logic b, logic [2:0] f, logic c, logic v, logic z, logic n);
    if (!b) return 1'b0;
    case (f)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return n != v;
      3'd5: return n == v;
      3'd6: return !c;
      3'd7: return c;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
    logic        br;
  } exp_t;

  exp_t q[$];
  exp_t e;
  bit   acc_m;

  // Scoreboard: at each negedge compare against the model of the current state,
  // then apply the upcoming edge's effects to the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, reset && (q.size() < 2));
      if (q.size() > 0 && out_valid) begin
        chk("sb_result", out_result, q[0].res);
        chk("sb_store", out_store_data, q[0].sd);
        chk("sb_rd", out_rd_addr, q[0].rd);
        chk("sb_ctrl", out_ctrl, q[0].ctrl);
        chk("sb_br", out_branch_taken, q[0].br);
      end
      if (!reset || flush) begin
        q.delete();
      end else begin
        acc_m = in_valid && (q.size() < 2);
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc_m) begin
          e.res  = alu_s;
          e.sd   = store_data;
          e.rd   = rd_addr;
          e.ctrl = ctrl_in;
          e.br   = br_ref(is_branch, br_funct3, alu_c, alu_v, alu_z, alu_n);
          q.push_back(e);
        end
      end
    end
  end

  logic [2:0] f3s [7] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
  logic       exp_br[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    reset = 1'b0; in_valid = 1'b0; alu_s = '0; store_data = '0;
    alu_c = 1'b0; alu_v = 1'b0; alu_z = 1'b0; alu_n = 1'b0;
    is_branch = 1'b0; br_funct3 = '0; rd_addr = '0; ctrl_in = '0;
    flush = 1'b0; out_ready = 1'b0;

    // Reset then pass-through
    step();
    mon_en = 1'b1;
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", out_result, 32'h0);
    chk("rst_rd", out_rd_addr, 5'h0);
    chk("rst_ctrl", out_ctrl, 4'h0);
    step();
    reset = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; alu_s = 32'h5; rd_addr = 5'd3; ctrl_in = 4'h4; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pt_valid", out_valid, 1'b1);
    chk("pt_result", out_result, 32'h5);
    chk("pt_rd", out_rd_addr, 5'd3);
    chk("pt_ctrl", out_ctrl, 4'h4);
    chk("pt_br", out_branch_taken, 1'b0);
    step();

    // Branch decode with {C,V,Z,N} = {0,0,0,1}
    is_branch = 1'b1; alu_c = 1'b0; alu_v = 1'b0; alu_z = 1'b0; alu_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      br_funct3 = f3s[i];
      alu_s = 32'h100 + i;
      step();
      chk($sformatf("br_f3_%0d", f3s[i]), out_branch_taken, exp_br[i]);
    end
    in_valid = 1'b0; is_branch = 1'b0; alu_n = 1'b0;
    step();

    // Backpressure and skid
    in_valid = 1'b1; alu_s = 32'h11;
    step();
    alu_s = 32'h22; out_ready = 1'b0;
    step();
    alu_s = 32'h33;
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_main", out_result, 32'h11);
    step();
    step();
    chk("bp_hold", out_result, 32'h11);
    out_ready = 1'b1;
    step();
    chk("bp_b", out_result, 32'h22);
    step();
    in_valid = 1'b0;
    chk("bp_c", out_result, 32'h33);
    chk("bp_c_valid", out_valid, 1'b1);
    step();
    chk("bp_drained", out_valid, 1'b0);

    // Flush with full buffer
    out_ready = 1'b0; in_valid = 1'b1; alu_s = 32'h44;
    step();
    alu_s = 32'h55;
    step();
    chk("fl_full", in_ready, 1'b0);
    alu_s = 32'h99; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_ready", in_ready, 1'b1);
    // Flush while in_ready=1 must also discard the incoming beat
    alu_s = 32'h66; in_valid = 1'b1;
    step();
    alu_s = 32'h99; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl2_valid", out_valid, 1'b0);
    step();
    chk("fl_no99", out_valid, 1'b0);

    // Reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1; alu_s = 32'h77; rd_addr = 5'd7; ctrl_in = 4'ha;
    step();
    in_valid = 1'b0;
    chk("mr_held", out_valid, 1'b1);
    reset = 1'b0;
    step();
    chk("mr_valid", out_valid, 1'b0);
    chk("mr_result", out_result, 32'h0);
    reset = 1'b1;
    in_valid = 1'b1; alu_s = 32'hCAFE_F00D; store_data = 32'h1234; rd_addr = 5'd9;
    ctrl_in = 4'h3; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mr_first", out_result, 32'hCAFE_F00D);
    chk("mr_store", out_store_data, 32'h1234);
    step();

`ifdef EX_MEM_STALL_CNT_EN
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("st_reset", stall_cycles, 32'd0);
    out_ready = 1'b0; in_valid = 1'b1; alu_s = 32'h1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    chk("st_count", stall_cycles, 32'd7);
    flush = 1'b1; out_ready = 1'b1;
    step();
    flush = 1'b0;
    chk("st_flush", stall_cycles, 32'd7);
`endif

    // Random traffic
    repeat (400) begin
      in_valid   = ($urandom % 4) != 0;
      alu_s      = $urandom;
      store_data = $urandom;
      rd_addr    = 5'($urandom);
      ctrl_in    = 4'($urandom);
      {alu_c, alu_v, alu_z, alu_n} = 4'($urandom);
      is_branch  = ($urandom % 2) != 0;
      br_funct3  = 3'($urandom);
      out_ready  = ($urandom % 3) != 0;
      flush      = ($urandom % 25) == 0;
      step();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("final_empty", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
